// File: rtl/gray_conv_scheduler.sv
// Round-robin sharing of one binary/gray converter between two requesters, registered result stage.
// Result valid 1 cycle after accept; out_ready low freezes the stage and deasserts both readies.
module gray_conv_scheduler #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             out_op,
  input  logic             out_ready,
  output logic [CNT_W-1:0] done_count
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic             state;
  logic             last_grant;
  logic             load_en;
  logic             grant0;
  logic             grant1;
  logic             sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] conv_data;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] d);
    return d ^ (d >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = d[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ d[i];
    end
    return b;
  endfunction

  assign out_valid = (state == ST_FULL);
  assign load_en   = !out_valid | out_ready;

  // On contention the requester not served last wins; last_grant resets to 1 so req0 wins first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (load_en) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = rst_n & grant0;
  assign req1_ready = rst_n & grant1;

  assign sel_op    = grant1 ? req1_op   : req0_op;
  assign sel_data  = grant1 ? req1_data : req0_data;
  assign conv_data = sel_op ? gray2bin(sel_data) : bin2gray(sel_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      out_data   <= '0;
      out_id     <= 1'b0;
      out_op     <= 1'b0;
      last_grant <= 1'b1;
      done_count <= '0;
    end else begin
      if (out_valid && out_ready) begin
        done_count <= done_count + CNT_W'(1);
      end
      if (grant0 || grant1) begin
        state      <= ST_FULL;
        out_data   <= conv_data;
        out_id     <= grant1;
        out_op     <= sel_op;
        last_grant <= grant1;
      end else if (out_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Directed and randomized checks of gray_conv_scheduler against a transaction-level model.
module tb_gray_conv_scheduler;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_op, req0_ready;
  logic [W-1:0]  req0_data;
  logic          req1_valid, req1_op, req1_ready;
  logic [W-1:0]  req1_data;
  logic          out_valid, out_id, out_op, out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] done_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: the result slot contents and who was served last.
  bit      m_valid;
  int      m_data, m_id, m_op, m_count, m_last;

  gray_conv_scheduler #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_op(out_op),
    .out_ready(out_ready), .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Gray->bin as a prefix XOR of all right shifts, bin->gray as d ^ d>>1.
  function automatic int ref_conv(input int op, input int d);
    int r;
    r = 0;
    if (op == 0) r = d ^ (d >> 1);
    else for (int k = 0; k < W; k++) r = r ^ (d >> k);
    return r & ((1 << W) - 1);
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_data = 0; m_id = 0; m_op = 0; m_count = 0; m_last = 1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"},  int'(out_valid),  int'(m_valid));
    check({tag, ".out_data"},   int'(out_data),   m_data);
    check({tag, ".out_id"},     int'(out_id),     m_id);
    check({tag, ".out_op"},     int'(out_op),     m_op);
    check({tag, ".done_count"}, int'(done_count), m_count);
  endtask

  // Called at a falling edge: drive, check readies, clock, check registered outputs.
  task automatic step(input string tag,
                      input bit v0, input bit o0, input int d0,
                      input bit v1, input bit o1, input int d1,
                      input bit ordy);
    int winner;
    bit slot_free;
    req0_valid = v0; req0_op = o0; req0_data = W'(d0);
    req1_valid = v1; req1_op = o1; req1_data = W'(d1);
    out_ready  = ordy;
    #1;
    slot_free = !m_valid || ordy;
    winner = -1;
    if (slot_free) begin
      if (v0 && v1) winner = 1 - m_last;
      else if (v0)  winner = 0;
      else if (v1)  winner = 1;
    end
    check({tag, ".req0_ready"}, int'(req0_ready), int'(winner == 0));
    check({tag, ".req1_ready"}, int'(req1_ready), int'(winner == 1));
    @(posedge clk);
    if (m_valid && ordy) m_count = (m_count + 1) % (1 << CW);
    if (winner >= 0) begin
      m_valid = 1;
      m_id    = winner;
      m_op    = (winner == 0) ? int'(o0) : int'(o1);
      m_data  = ref_conv(m_op, (winner == 0) ? d0 : d1);
      m_last  = winner;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 4'b0101;
    req1_valid = 1'b1; req1_op = 1'b1; req1_data = 4'b1000;
    out_ready  = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst.req0_ready", int'(req0_ready), 0);
    check("rst.req1_ready", int'(req1_ready), 0);
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    step("idle", 0, 0, 0, 0, 0, 0, 1);
    step("r0_b2g", 1, 0, 4'b0101, 0, 0, 0, 1);
    check("r0_b2g.data_lit", int'(out_data), 4'b0111);
    step("drain", 0, 0, 0, 0, 0, 0, 1);
    check("drain.count_lit", int'(done_count), 1);
    step("r1_g2b_a", 0, 0, 0, 1, 1, 4'b1000, 1);
    check("r1_g2b_a.data_lit", int'(out_data), 4'b1111);
    step("r1_g2b_b", 0, 0, 0, 1, 1, 4'b0111, 1);
    check("r1_g2b_b.data_lit", int'(out_data), 4'b0101);
    step("drain2", 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++) begin
      step("alt", 1, 0, 4'b0011, 1, 0, 4'b1100, 1);
      check("alt.data_lit", int'(out_data), (i % 2 == 0) ? 4'b0010 : 4'b1010);
    end

    for (int i = 0; i < 3; i++) step("stall", 1, 0, 4'b0110, 1, 1, 4'b1001, 0);
    step("resume", 1, 0, 4'b0110, 1, 1, 4'b1001, 1);
    step("resume2", 1, 1, 4'b1110, 1, 0, 4'b0001, 1);

    // Drop valid without transfer while stalled: nothing may change.
    step("hold", 1, 0, 4'b0001, 0, 0, 0, 0);
    step("hold2", 0, 0, 0, 0, 0, 0, 0);
    step("drain3", 0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset while FULL.
    step("fill", 1, 1, 4'b1011, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.out_valid", int'(out_valid), 0);
    check("arst.done_count", int'(done_count), 0);
    check("arst.req0_ready", int'(req0_ready), 0);
    check_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_arst", 1, 0, 4'b1111, 1, 0, 4'b0000, 1);

    for (int i = 0; i < 400; i++) begin
      step("rand",
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_conv_scheduler.md
Name: gray_conv_scheduler

Overview:
- Shares one binary/gray conversion datapath between two requesters.
- Each request carries an op bit: 0 = binary-to-gray, 1 = gray-to-binary.
- Round-robin arbitration; a single registered output stage with valid/ready handshake; counter of completed conversions.
- Sits between producer blocks and the downstream consumer of converted codes.

Parameters:
- WIDTH, 4, bit width of data words (>=2).
- CNT_W, 16, width of the completed-conversion counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a word.
- req0_op  in  1  requester 0 operation (0 bin->gray, 1 gray->bin).
- req0_data  in  WIDTH  requester 0 input word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_op  in  1  requester 1 operation.
- req1_data  in  WIDTH  requester 1 input word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- out_valid  out  1  out_data holds a converted result.
- out_data  out  WIDTH  converted word.
- out_id  out  1  requester that issued the result.
- out_op  out  1  op used for the result.
- out_ready  in  1  consumer accepts the result this cycle.
- done_count  out  CNT_W  results consumed since reset.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_id=0, out_op=0, done_count=0, last_grant=1 (requester 0 wins the first tie). req*_ready=0 while in reset.
- Conversion: bin->gray g = d ^ (d>>1). gray->bin: b[WIDTH-1] = d[WIDTH-1]; b[i] = b[i+1] ^ d[i] for i = WIDTH-2 down to 0. Purely combinational ahead of the output register.
- Load enable: load_en = !out_valid | out_ready. The stage may reload in the same cycle it drains, giving a throughput of one result per cycle.
- Grant (combinational, only when load_en=1):
  - Only one requester valid: grant it.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- reqN_ready = load_en & grantN. At most one ready is high per cycle. Ready may depend combinationally on valid; requesters must not make valid depend on ready.
- Transfer: a request transfers on reqN_valid & reqN_ready. On the next edge:
  - out_data = converted word, out_id = N, out_op = reqN_op, out_valid = 1.
  - last_grant = N.
- Latency: 1 cycle from accepted request to out_valid.
- Drain: out_valid & out_ready & no new grant -> out_valid=0 next edge. out_data, out_id and out_op hold their last values.
- Backpressure: out_valid=1 & out_ready=0 -> the output register holds stable, both req*_ready=0, last_grant unchanged.
- Counter: done_count increments on each out_valid & out_ready. It wraps modulo 2^CNT_W, with no saturation.
- Simultaneous drain + load: the counter increments and the new result loads in the same edge.
- Requester dropping valid without a transfer is legal; no state changes.
- Reset mid-operation: a pending result is discarded, the counter clears, and arbitration restarts with requester 0 priority.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on a grant.
  - FULL -> FULL on drain with a new grant, or on stall.
  - FULL -> EMPTY on drain with no grant.

Test Plan:
- Reset release, no requests -> out_valid=0, req0_ready=req1_ready=0 for the first cycle only if no valid; done_count=0.
- req0 only, op=0, data=4'b0101, out_ready=1 -> req0_ready=1 same cycle; next cycle out_data=4'b0111, out_id=0, out_op=0; done_count=1 after consume.
- req1 only, op=1, data=4'b1000 -> out_data=4'b1111, out_id=1; data=4'b0111 -> 4'b0101.
- Both valid continuously, out_ready=1, with req0 data 4'b0011 op0 and req1 data 4'b1100 op0 -> grants alternate 0,1,0,1; outputs alternate 4'b0010 and 4'b1010 every cycle; done_count increments each cycle.
- Backpressure: result held with out_ready=0 for 3 cycles while both request -> out_* stable, both readies 0, no count change; then out_ready=1 -> winner is the requester not last granted.
- Counter wrap with CNT_W=2: 5 consumed results -> done_count 1,2,3,0,1. Separately, assert rst_n=0 while FULL -> out_valid=0 immediately (asynchronously), done_count=0.
